input_conditioner: RTL and testbench

Parametrised multi-channel front-end for asynchronous board inputs (buttons, switches) that sits between the FPGA pins and the CPU/top-level logic. It replaces the single-mode button debouncer with per-channel synchronisation, debounce, and runtime-selectable event generation: press pulse, release pulse, auto-repeat, or plain level. It also reports long presses. One instance serves all user inputs and is clocked by the CPU clock.

---
 rtl/input_conditioner.sv | 201 ++++++++++++++++++++
 tb/tb_input_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Multi-channel front end for asynchronous board inputs (buttons, switches).
// Each channel is synchronised and debounced, then drives a small press FSM
// that reports the debounced level and generates mode-selected event strobes
// (press, release, auto-repeat or none) plus a long-press strobe.
//
// Ports
//   clk         CPU clock, all state on its rising edge
//   rst_n       asynchronous active-low reset, clears every flop
//   in          [WIDTH]     raw asynchronous inputs, active high
//   mode        [2*WIDTH]   per-channel mode, bits [2i+1:2i]:
//                           00 press, 01 release, 10 auto-repeat, 11 level only
//   level       [WIDTH]     debounced level per channel (registered)
//   pulse       [WIDTH]     one-cycle event strobe per channel (registered)
//   long_press  [WIDTH]     one-cycle strobe when a hold reaches LONG_CNT_MAX
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SAMPLE_CNT_MAX = 25000,
  parameter int unsigned PULSE_CNT_MAX  = 200,
  parameter int unsigned LONG_CNT_MAX   = 2000,
  parameter int unsigned REPEAT_CNT_MAX = 400
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in,
  input  logic [2*WIDTH-1:0] mode,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   pulse,
  output logic [WIDTH-1:0]   long_press
);

  // A one-cycle sample period still needs a 1-bit timer register.
  localparam int unsigned TMR_W  = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int unsigned CNT_W  = $clog2(PULSE_CNT_MAX + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CNT_MAX + 1);
  localparam int unsigned REP_W  = $clog2(REPEAT_CNT_MAX + 1);

  localparam logic [1:0] MODE_PRESS   = 2'b00;
  localparam logic [1:0] MODE_RELEASE = 2'b01;
  localparam logic [1:0] MODE_REPEAT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Shared sample timer: tick_c marks the last cycle of each sample period.
  // ---------------------------------------------------------------------------
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tick_c;

  assign tick_c = (tmr_q == TMR_W'(SAMPLE_CNT_MAX - 1));

  always_comb begin
    tmr_d = tmr_q + TMR_W'(1);
    if (tick_c) begin
      tmr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel synchroniser, debounce counter and press FSM.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_c;
    logic [1:0]             mode_c;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [REP_W-1:0]       rep_q, rep_d;
    state_e                 state_q, state_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   long_q, long_d;
    logic                   accept_c;

    assign s_c    = sync_q[SYNC_STAGES-1];
    assign mode_c = mode[2*i +: 2];

    // Synchroniser chain for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in[i]};
      end
    end

    // Consecutive-high sample counter, saturating at PULSE_CNT_MAX.
    always_comb begin
      cnt_d = cnt_q;
      if (tick_c) begin
        if (!s_c) begin
          cnt_d = '0;
        end else if (cnt_q != CNT_W'(PULSE_CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Press accepted on the tick where the counter reaches its maximum.
    assign accept_c = s_c && (cnt_d == CNT_W'(PULSE_CNT_MAX));

    // Next-state and output logic; events are only produced on a tick.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      level_d = level_q;
      pulse_d = 1'b0;
      long_d  = 1'b0;
      if (tick_c) begin
        case (state_q)
          ST_IDLE: begin
            if (accept_c) begin
              level_d = 1'b1;
              hold_d  = '0;
              state_d = ST_HELD;
              pulse_d = (mode_c == MODE_PRESS) || (mode_c == MODE_REPEAT);
            end
          end
          ST_HELD: begin
            if (!s_c) begin
              level_d = 1'b0;
              state_d = ST_IDLE;
              pulse_d = (mode_c == MODE_RELEASE);
            end else begin
              if (hold_q != HOLD_W'(LONG_CNT_MAX)) begin
                hold_d = hold_q + HOLD_W'(1);
              end
              if (hold_d == HOLD_W'(LONG_CNT_MAX)) begin
                long_d  = 1'b1;
                rep_d   = '0;
                state_d = ST_LONG;
              end
            end
          end
          ST_LONG: begin
            if (!s_c) begin
              level_d = 1'b0;
              state_d = ST_IDLE;
              pulse_d = (mode_c == MODE_RELEASE);
            end else if (mode_c == MODE_REPEAT) begin
              // Repeat interval only advances while in auto-repeat mode.
              if (rep_q != REP_W'(REPEAT_CNT_MAX)) begin
                rep_d = rep_q + REP_W'(1);
              end
              if (rep_d == REP_W'(REPEAT_CNT_MAX)) begin
                pulse_d = 1'b1;
                rep_d   = '0;
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            level_d = 1'b0;
          end
        endcase
      end
    end

    // Channel state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        hold_q  <= '0;
        rep_q   <= '0;
        state_q <= ST_IDLE;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        rep_q   <= rep_d;
        state_q <= state_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
        long_q  <= long_d;
      end
    end

    assign level[i]      = level_q;
    assign pulse[i]      = pulse_q;
    assign long_press[i] = long_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int unsigned W  = 4;
  localparam int unsigned MW = 2 * W;
  localparam int          SY = 2;
  localparam int          S  = 4;
  localparam int          P  = 3;
  localparam int          L  = 5;
  localparam int          R  = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in    = '0;
  logic [MW-1:0] mode  = '0;
  logic [W-1:0]  level, pulse, long_press;

  input_conditioner #(
    .WIDTH(W), .SYNC_STAGES(SY), .SAMPLE_CNT_MAX(S),
    .PULSE_CNT_MAX(P), .LONG_CNT_MAX(L), .REPEAT_CNT_MAX(R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .mode(mode),
    .level(level), .pulse(pulse), .long_press(long_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] lvl;
    logic [W-1:0] pls;
    logic [W-1:0] lng;
  } ev_t;

  ev_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  int  rise1 = -1;

  // Reference model: input history, sample phase and per-channel hold bookkeeping.
  logic [W-1:0] hist[$];
  int           m_tmr;
  int           run[W], held[W], rep[W];
  bit           pressed[W], long_done[W];
  logic [W-1:0] m_lvl;

  always @(posedge clk) begin : model
    logic [W-1:0] s, nl, np, ng;
    logic [1:0]   m;
    bit           tick;
    cyc = cyc + 1;
    if (!rst_n) begin
      hist.delete();
      for (int k = 0; k < SY; k++) hist.push_back('0);
      m_tmr = 0;
      m_lvl = '0;
      for (int i = 0; i < int'(W); i++) begin
        run[i] = 0; held[i] = 0; rep[i] = 0; pressed[i] = 0; long_done[i] = 0;
      end
    end else begin
      tick  = (m_tmr == S - 1);
      m_tmr = tick ? 0 : m_tmr + 1;
      s     = hist.pop_front();
      hist.push_back(in);
      nl = m_lvl; np = '0; ng = '0;
      if (tick) begin
        for (int i = 0; i < int'(W); i++) begin
          m = mode[2*i +: 2];
          run[i] = s[i] ? ((run[i] < P) ? run[i] + 1 : P) : 0;
          if (!pressed[i]) begin
            if (s[i] && run[i] == P) begin
              pressed[i] = 1; held[i] = 0; long_done[i] = 0; rep[i] = 0;
              nl[i] = 1'b1;
              np[i] = (m == 2'b00) || (m == 2'b10);
            end
          end else if (!s[i]) begin
            pressed[i] = 0;
            nl[i] = 1'b0;
            np[i] = (m == 2'b01);
          end else if (!long_done[i]) begin
            held[i] = held[i] + 1;
            if (held[i] == L) begin
              ng[i] = 1'b1; long_done[i] = 1; rep[i] = 0;
            end
          end else if (m == 2'b10) begin
            rep[i] = rep[i] + 1;
            if (rep[i] == R) begin
              np[i] = 1'b1; rep[i] = 0;
            end
          end
        end
      end
      if (np != '0 || ng != '0 || nl != m_lvl) begin
        sb_q.push_back('{cyc: cyc, lvl: nl, pls: np, lng: ng});
      end
      m_lvl = nl;
    end
  end

  // Monitor: any visible output activity must match the next scoreboard entry.
  logic [W-1:0] prev_lvl = '0;
  always @(negedge clk) begin : monitor
    ev_t e;
    if (!rst_n) begin
      n_cmp = n_cmp + 1;
      if (level !== '0 || pulse !== '0 || long_press !== '0) begin
        n_bad = n_bad + 1;
        $display("FAIL reset_zero cyc=%0d level=%h pulse=%h long=%h required all 0",
                 cyc, level, pulse, long_press);
      end
      sb_q.delete();
      prev_lvl = '0;
    end else begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL missed_event cyc=%0d exp level=%h pulse=%h long=%h, DUT silent",
                 sb_q[0].cyc, sb_q[0].lvl, sb_q[0].pls, sb_q[0].lng);
        void'(sb_q.pop_front());
      end
      if (pulse !== '0 || long_press !== '0 || level !== prev_lvl) begin
        n_cmp = n_cmp + 1;
        if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
          n_bad = n_bad + 1;
          $display("FAIL unexpected_event cyc=%0d level=%h pulse=%h long=%h, required no change",
                   cyc, level, pulse, long_press);
        end else begin
          e = sb_q.pop_front();
          if (e.lvl !== level || e.pls !== pulse || e.lng !== long_press) begin
            n_bad = n_bad + 1;
            $display("FAIL event_value cyc=%0d level=%h/%h pulse=%h/%h long=%h/%h (actual/required)",
                     cyc, level, e.lvl, pulse, e.pls, long_press, e.lng);
          end
        end
      end
      if (level[1] && !prev_lvl[1]) rise1 = cyc;
      prev_lvl = level;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : stim
    int t0;
    // Reset with all inputs high, then release and debounce from zero.
    rst_n = 1'b0; in = '1; mode = '0;
    step(4);
    rst_n = 1'b1;
    step(24);
    in = '0;
    step(16);

    // Glitch on ch0: only two high samples.
    in[0] = 1'b1; step(8); in[0] = 1'b0; step(20);

    // ch1 press mode: held 10 ticks, with latency check.
    mode[3:2] = 2'b00;
    rise1 = -1;
    in[1] = 1'b1; t0 = cyc;
    step(40);
    n_cmp = n_cmp + 1;
    if (rise1 < 0 || rise1 - t0 < 11 || rise1 - t0 > 15) begin
      n_bad = n_bad + 1;
      $display("FAIL press_latency actual=%0d required 11..15", (rise1 < 0) ? -1 : rise1 - t0);
    end
    in[1] = 1'b0; step(20);

    // ch1 release mode.
    mode[3:2] = 2'b01;
    in[1] = 1'b1; step(40); in[1] = 1'b0; step(20);

    // ch2 auto-repeat.
    mode[5:4] = 2'b10;
    in[2] = 1'b1; step(80); in[2] = 1'b0; step(20);

    // ch3 level-only with ch0 press, concurrently.
    mode[7:6] = 2'b11; mode[1:0] = 2'b00;
    in[3] = 1'b1; in[0] = 1'b1; step(40);
    in[3] = 1'b0; in[0] = 1'b0; step(20);

    // Reset during a long hold on ch2, input kept high through it.
    mode[5:4] = 2'b10;
    in[2] = 1'b1; step(50);
    rst_n = 1'b0; step(3);
    rst_n = 1'b1; step(30);
    in[2] = 1'b0; step(20);

    // Random toggling and occasional mode changes.
    repeat (3000) begin
      for (int i = 0; i < int'(W); i++) begin
        if ($urandom_range(0, 29) == 0) in[i] = ~in[i];
      end
      if ($urandom_range(0, 299) == 0) mode = MW'($urandom);
      step(1);
    end

    in = '0;
    step(40);
    n_cmp = n_cmp + 1;
    if (sb_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL leftover_events actual=%0d required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
